frame_normalize: RTL
====================

Name: frame_normalize

Overview:
Block-floating-point normaliser for the LPC front end. It consumes the same sample stream that feeds the peak detector: signed 16-bit x, qualified by a valid strobe v. It buffers one frame while tracking the peak magnitude, derives a common left-shift, then replays the frame scaled so that the peak magnitude lands in [0x4000, 0x7FFF]. The result feeds autocorrelation with maximum headroom-safe precision, and the shift is exported so downstream blocks can undo the gain.

Parameters:
FRAME_LEN, 256, samples per frame (power of two, at least 4)
ADDR_W, 8, log2(FRAME_LEN)
DW, 16, sample width (signed)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
x  in  DW  signed input sample
v  in  1  input sample valid
in_ready  out  1  high while the block accepts samples (FILL state)
y  out  DW  signed normalised sample
vout  out  1  y valid
last  out  1  high with the final y of a frame
shift  out  4  left-shift applied to the current/last frame (0..14)
shift_valid  out  1  one-cycle pulse when shift updates
overrun  out  1  sticky: v seen while in_ready low

Behaviour:
- Reset (rst_n=0 at a clock edge) gives y=0, vout=0, last=0, shift=0, shift_valid=0, overrun=0, in_ready=1, state=FILL, write address=0, maxabs=0.
- Reset mid-frame discards any partial frame or drain in progress. There is no output in the cycle after reset.
- FSM states are FILL, CALC and DRAIN.
- FILL, on each cycle with v=1:
  - write x to buffer[wa] and increment wa;
  - update maxabs = max(maxabs, |x|). |x| is 15-bit, and -32768 saturates to 32767.
  - When the FRAME_LEN-th sample is accepted (wa wraps to 0), the next state is CALC and in_ready drops the following cycle.
- CALC (one cycle):
  - shift = (count of leading zeros of {1'b0, maxabs} as 16-bit) - 1, clamped to the range 0..14;
  - maxabs=0 gives shift=0;
  - shift_valid pulses for this one cycle, with shift registered;
  - maxabs is cleared and ra is set to 0, then the state moves to DRAIN.
- DRAIN:
  - read buffer[ra] each cycle and increment ra; the RAM has 1-cycle read latency;
  - y = buffer data arithmetically shifted left by shift; no saturation is needed because |y| <= 0x7FFF by construction;
  - vout is high for exactly FRAME_LEN consecutive cycles; last is high with the final one;
  - after the last read is issued the state moves to FILL, and in_ready rises the cycle after the final vout.
- Latency:
  - the last input is accepted at edge k, and shift_valid is seen at k+1;
  - the first vout is at k+3 and the final vout is at k+2+FRAME_LEN;
  - in_ready=1 from k+3+FRAME_LEN.
- v=1 while in_ready=0 drops the sample and sets overrun. overrun clears only on reset.
- v gaps during FILL are allowed; the frame completes only after FRAME_LEN accepted samples.
- shift holds its value until the next CALC.

Decomposition:
- Shared package lpc_pkg holds:
  - SAMPLE_W=16;
  - default FRAME_LEN/ADDR_W;
  - SHIFT_W=4;
  - the FSM state encoding (FILL, CALC, DRAIN).
- One sub-module: frame_ram, a simple dual-port synchronous RAM (DW x FRAME_LEN, registered read, inferrable).
- The leading-zero count is a local function, not a module.

Test Plan:
- Frame of FRAME_LEN samples with peak 0x4000 and the rest small -> shift=0, y equals x, vout run of 256, last on the 256th.
- Frame with max |x|=0x0100, including sample -0x0100 -> shift=6, that sample yields y=-0x4000, peak sample yields 0x4000.
- All-zero frame -> shift=0, 256 zero outputs. Frame containing 1 as max -> shift=14, y=0x4000.
- Frame containing -32768 -> maxabs saturates to 32767, shift=0, y=-32768 unchanged.
- v held high through CALC/DRAIN -> those samples dropped, overrun=1. Next frame starts only at in_ready=1; latency k+1/k+3/k+2+FRAME_LEN checked.
- rst_n low for 1 cycle mid-DRAIN -> vout=0 next cycle, in_ready=1, shift=0, overrun=0. A following full frame normalises correctly.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC front end.
// Holds the default sample/frame geometry, the shift width and the
// state encoding used by frame_normalize.
package lpc_pkg;

   localparam int SAMPLE_W      = 16;
   localparam int FRAME_LEN_DEF = 256;
   localparam int ADDR_W_DEF    = 8;
   localparam int SHIFT_W       = 4;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_CALC  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port synchronous RAM holding one frame of samples.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i     read port; rdata_o is valid one cycle after re_i
module frame_ram #(
   parameter int DW = 16,
   parameter int AW = 8
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/frame_normalize.sv
// Block-floating-point frame normaliser.
// Buffers one frame while tracking the peak magnitude, derives a common
// left shift that puts the peak in [0x4000, 0x7FFF], then replays the
// frame scaled by that shift.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   x, v              input sample and its valid strobe
//   in_ready          high while samples are accepted (FILL state)
//   y, vout, last     normalised sample, its valid, end-of-frame marker
//   shift             shift applied to the current/last frame
//   shift_valid       one-cycle pulse when shift updates
//   overrun           sticky: v seen while in_ready was low
//   dbg_state         current FSM state (debug)
// Handshake: a sample is taken on a rising edge where v and in_ready are
// both high; v with in_ready low drops the sample and sets overrun.
// vout has no back-pressure: a frame drains as one unbroken burst.
module frame_normalize
   import lpc_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DW        = SAMPLE_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DW-1:0]      x,
   input  logic               v,
   output logic               in_ready,
   output logic [DW-1:0]      y,
   output logic               vout,
   output logic               last,
   output logic [SHIFT_W-1:0] shift,
   output logic               shift_valid,
   output logic               overrun,
   output logic [1:0]         dbg_state
);

   // The drain counter runs two cycles past the last read so the FSM
   // returns to FILL only once the final sample has left the y register.
   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0]      DC_ONE     = CW'(1);
   localparam logic [CW-1:0]      DC_LAST_RD = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0]      DC_END     = CW'(FRAME_LEN + 1);
   localparam logic [ADDR_W-1:0]  WA_ONE     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0]  WA_LAST    = ADDR_W'(FRAME_LEN - 1);
   localparam logic [DW-2:0]      MAG_ONE    = (DW-1)'(1);
   localparam logic [SHIFT_W:0]   LZ_ONE     = (SHIFT_W+1)'(1);
   localparam logic [SHIFT_W:0]   LZ_CLAMP   = (SHIFT_W+1)'(DW - 2);

   // |s| as a DW-1 bit magnitude; the most negative value saturates.
   function automatic logic [DW-2:0] mag_sat(input logic [DW-1:0] s);
      logic [DW-2:0] m;
      if (!s[DW-1])                m = s[DW-2:0];
      else if (s[DW-2:0] == '0)    m = '1;
      else                         m = ~s[DW-2:0] + MAG_ONE;
      return m;
   endfunction

   function automatic logic [SHIFT_W:0] lzc(input logic [DW-1:0] val);
      logic [SHIFT_W:0] n;
      n = (SHIFT_W+1)'(DW);
      for (int i = 0; i < DW; i++) begin
         if (val[i]) n = (SHIFT_W+1)'(DW - 1 - i);
      end
      return n;
   endfunction

   // Sign bit is always a leading zero, hence the -1; zero peak means no gain.
   function automatic logic [SHIFT_W-1:0] calc_shift(input logic [DW-2:0] m);
      logic [SHIFT_W:0]   lz_m1;
      logic [SHIFT_W-1:0] s;
      lz_m1 = lzc({1'b0, m}) - LZ_ONE;
      if (m == '0)               s = '0;
      else if (lz_m1 > LZ_CLAMP) s = LZ_CLAMP[SHIFT_W-1:0];
      else                       s = lz_m1[SHIFT_W-1:0];
      return s;
   endfunction

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  wa_q, wa_d;
   logic [DW-2:0]      maxabs_q, maxabs_d;
   logic [CW-1:0]      dc_q, dc_d;
   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic               shift_valid_q, shift_valid_d;
   logic               overrun_q, overrun_d;

   logic               ram_we, ram_re, ram_last;
   logic [DW-1:0]      ram_rdata;
   logic [DW-2:0]      x_mag;

   logic               rd_valid_q, rd_last_q;
   logic [DW-1:0]      y_q;
   logic               vout_q, last_q;

   assign x_mag = mag_sat(x);

   always_comb begin
      state_d       = state_q;
      wa_d          = wa_q;
      maxabs_d      = maxabs_q;
      dc_d          = dc_q;
      shift_d       = shift_q;
      shift_valid_d = 1'b0;
      overrun_d     = overrun_q;
      ram_we        = 1'b0;
      ram_re        = 1'b0;
      ram_last      = 1'b0;
      in_ready      = (state_q == ST_FILL);

      if (v && !in_ready) overrun_d = 1'b1;

      unique case (state_q)
         ST_FILL: begin
            if (v) begin
               ram_we = 1'b1;
               wa_d   = wa_q + WA_ONE;
               if (x_mag > maxabs_q) maxabs_d = x_mag;
               if (wa_q == WA_LAST) state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            shift_d       = calc_shift(maxabs_q);
            shift_valid_d = 1'b1;
            maxabs_d      = '0;
            dc_d          = '0;
            state_d       = ST_DRAIN;
         end
         ST_DRAIN: begin
            ram_re   = (dc_q <= DC_LAST_RD);
            ram_last = (dc_q == DC_LAST_RD);
            dc_d     = dc_q + DC_ONE;
            if (dc_q == DC_END) state_d = ST_FILL;
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_FILL;
         wa_q          <= '0;
         maxabs_q      <= '0;
         dc_q          <= '0;
         shift_q       <= '0;
         shift_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wa_q          <= wa_d;
         maxabs_q      <= maxabs_d;
         dc_q          <= dc_d;
         shift_q       <= shift_d;
         shift_valid_q <= shift_valid_d;
         overrun_q     <= overrun_d;
      end
   end

   // Output pipeline: RAM read stage, then the scaled y register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         y_q        <= '0;
         vout_q     <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         rd_valid_q <= ram_re;
         rd_last_q  <= ram_last;
         y_q        <= rd_valid_q ? (ram_rdata << shift_q) : '0;
         vout_q     <= rd_valid_q;
         last_q     <= rd_last_q;
      end
   end

   frame_ram #(
      .DW (DW),
      .AW (ADDR_W)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (wa_q),
      .wdata_i (x),
      .re_i    (ram_re),
      .raddr_i (dc_q[ADDR_W-1:0]),
      .rdata_o (ram_rdata)
   );

   assign y           = y_q;
   assign vout        = vout_q;
   assign last        = last_q;
   assign shift       = shift_q;
   assign shift_valid = shift_valid_q;
   assign overrun     = overrun_q;
   assign dbg_state   = state_q;

endmodule
